cpu_controller: RTL

Multicycle control unit that drives every control input of `CPUdatapath`. It takes the instruction register and the S/V/Z/C flags back from the datapath and sequences fetch, PC increment, decode, operand fetch and execute as a Moore state machine. It sits beside `CPUdatapath` in the CPU top level. It also owns the memory read/write handshake toward the memory model.

---
 rtl/cpu_controller.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_controller.sv
// Multicycle control unit for CPUdatapath: a Moore FSM that sequences fetch,
// PC increment, decode, operand-word fetch and execute, and owns the
// memrd/memwr handshake toward memory.
//
// Memory handshake: in a wait state (F1, O1, L1, S2) the strobe stays high
// until mready is seen high. The transfer completes in the cycle mready=1.
// Any load enable tied to that transfer is asserted only in that cycle.
// mready is ignored in every other state.
module cpu_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IRout,
  input  logic        Sout,
  input  logic        Vout,
  input  logic        Zout,
  input  logic        Cout,
  input  logic        mready,
  output logic        ldbuf,
  output logic        ldflags,
  output logic        ldPC,
  output logic        ld2,
  output logic        ldtemp,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        ldIR,
  output logic        TPC,
  output logic        Tr2,
  output logic        Ttemp,
  output logic        TMAR,
  output logic        TMDR2X,
  output logic        TMDR,
  output logic        add,
  output logic        transx,
  output logic        rdR,
  output logic        wR,
  output logic        rMDRi,
  output logic        rMDRX,
  output logic [1:0]  sel1,
  output logic        memrd,
  output logic        memwr,
  output logic        halted,
  output logic        illegal,
  output logic [4:0]  state_dbg
);

  typedef enum logic [4:0] {
    S_IDLE, S_F0, S_F1, S_P0, S_P1, S_D,
    S_O0, S_O1, S_O2, S_O3,
    S_A0, S_A1, S_A2,
    S_X, S_L0, S_L1, S_L2,
    S_S0, S_S1, S_S2,
    S_J0, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_MVI = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_JS  = 4'hB;
  localparam logic [3:0] OP_JV  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state, state_nxt;
  logic [3:0] op;
  logic       cond_taken;
  logic       unused_ir_bits;

  assign op             = IRout[15:12];
  assign unused_ir_bits = ^IRout[11:0];
  assign state_dbg      = state;

  // Flag selected by the conditional-jump opcode.
  always_comb begin
    cond_taken = 1'b0;
    case (op)
      OP_JZ:   cond_taken = Zout;
      OP_JC:   cond_taken = Cout;
      OP_JS:   cond_taken = Sout;
      OP_JV:   cond_taken = Vout;
      default: cond_taken = 1'b0;
    endcase
  end

  // State register; reset aborts any access in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_F0;
      S_F0:   state_nxt = S_F1;
      S_F1:   if (mready) state_nxt = S_P0;
      S_P0:   state_nxt = S_P1;
      S_P1:   state_nxt = S_D;
      S_D: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR:        state_nxt = S_A0;
          OP_LD, OP_ST, OP_MVI, OP_JMP,
          OP_JZ, OP_JC, OP_JS, OP_JV:           state_nxt = S_O0;
          OP_HLT:                               state_nxt = S_HALT;
          default:                              state_nxt = S_F0;
        endcase
      end
      S_O0:   state_nxt = S_O1;
      S_O1:   if (mready) state_nxt = S_O2;
      S_O2:   state_nxt = S_O3;
      S_O3: begin
        case (op)
          OP_MVI:                     state_nxt = S_X;
          OP_LD:                      state_nxt = S_L0;
          OP_ST:                      state_nxt = S_S0;
          OP_JMP:                     state_nxt = S_J0;
          OP_JZ, OP_JC, OP_JS, OP_JV: state_nxt = cond_taken ? S_J0 : S_F0;
          default:                    state_nxt = S_F0;
        endcase
      end
      S_A0:   state_nxt = S_A1;
      S_A1:   state_nxt = S_A2;
      S_A2:   state_nxt = S_F0;
      S_X:    state_nxt = S_F0;
      S_L0:   state_nxt = S_L1;
      S_L1:   if (mready) state_nxt = S_L2;
      S_L2:   state_nxt = S_F0;
      S_S0:   state_nxt = S_S1;
      S_S1:   state_nxt = S_S2;
      S_S2:   if (mready) state_nxt = S_F0;
      S_J0:   state_nxt = S_F0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state (wait-state loads gated by mready).
  always_comb begin
    ldbuf = 1'b0; ldflags = 1'b0; ldPC = 1'b0; ld2 = 1'b0;
    ldtemp = 1'b0; ldMAR = 1'b0; ldMDR = 1'b0; ldIR = 1'b0;
    TPC = 1'b0; Tr2 = 1'b0; Ttemp = 1'b0; TMAR = 1'b0;
    TMDR2X = 1'b0; TMDR = 1'b0;
    add = 1'b0; transx = 1'b0; rdR = 1'b0; wR = 1'b0;
    rMDRi = 1'b0; rMDRX = 1'b0;
    sel1 = 2'b00;
    memrd = 1'b0; memwr = 1'b0; halted = 1'b0; illegal = 1'b0;
    case (state)
      S_F0, S_O0: begin
        TPC = 1'b1; transx = 1'b1; ldMAR = 1'b1;
      end
      S_F1: begin
        TMAR = 1'b1; memrd = 1'b1; ldIR = mready;
      end
      S_P0, S_O2: begin
        TPC = 1'b1; ld2 = 1'b1; ldbuf = 1'b1;
      end
      S_P1, S_O3: begin
        Tr2 = 1'b1; add = 1'b1; ldPC = 1'b1;
      end
      S_D: begin
        illegal = (op == 4'hD) || (op == 4'hE);
      end
      S_O1, S_L1: begin
        TMAR = 1'b1; memrd = 1'b1; ldMDR = mready; rMDRX = mready;
      end
      S_A0: begin
        rdR = 1'b1; ld2 = 1'b1;
      end
      S_A1: begin
        Tr2 = 1'b1; add = 1'b1; ldflags = 1'b1; ldtemp = 1'b1;
        case (op)
          OP_SUB:  sel1 = 2'b01;
          OP_AND:  sel1 = 2'b10;
          OP_OR:   sel1 = 2'b11;
          default: sel1 = 2'b00;
        endcase
      end
      S_A2: begin
        Ttemp = 1'b1; transx = 1'b1; wR = 1'b1;
      end
      S_X, S_L2: begin
        TMDR2X = 1'b1; transx = 1'b1; wR = 1'b1;
      end
      S_L0, S_S0: begin
        TMDR2X = 1'b1; transx = 1'b1; ldMAR = 1'b1;
      end
      S_S1: begin
        rdR = 1'b1; ldMDR = 1'b1; rMDRi = 1'b1;
      end
      S_S2: begin
        TMAR = 1'b1; TMDR = 1'b1; memwr = 1'b1;
      end
      S_J0: begin
        TMDR2X = 1'b1; transx = 1'b1; ldPC = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
